// File: rtl/btb_predictor_if.sv
// Lookup and update bus for the IF-stage branch target buffer.
// The master side is the pipeline (fetch PC and EX_MEM resolution); the slave side is the BTB.
interface btb_predictor_if #(
    parameter int WORD = 16
);
    logic [WORD-1:0] pc;
    logic [WORD-1:0] predicted_pc;
    logic            no_btb;
    logic            predict_taken;
    logic            update_valid;
    logic [WORD-1:0] update_pc;
    logic [WORD-1:0] update_target;
    logic            update_taken;
    logic [15:0]     hit_count;

    modport master (
        output pc, update_valid, update_pc, update_target, update_taken,
        input  predicted_pc, no_btb, predict_taken, hit_count
    );

    modport slave (
        input  pc, update_valid, update_pc, update_target, update_taken,
        output predicted_pc, no_btb, predict_taken, hit_count
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC, registered update from EX_MEM.
// Optional macro BTB_COUNTER_EN adds a 2-bit saturating direction counter per entry.
module btb_predictor #(
    parameter int WORD       = 16,
    parameter int INDEX_BITS = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    btb_predictor_if.slave btb
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD - INDEX_BITS;
    localparam logic [WORD-1:0] PC_STEP = WORD'(1);

    typedef struct packed {
        logic            vld;
        logic [WORD-1:0] pc;
        logic [WORD-1:0] target;
        logic            taken;
    } upd_req_t;

    upd_req_t upd;
    assign upd = '{vld: btb.update_valid, pc: btb.update_pc,
                   target: btb.update_target, taken: btb.update_taken};

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][WORD-1:0]  target_q;
`ifdef BTB_COUNTER_EN
    logic [ENTRIES-1:0][1:0]       ctr_q;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'b01;
        else   return (c == 2'b00) ? c : c - 2'b01;
    endfunction
`endif

    // Lookup: reads pre-update contents, gated off while in reset.
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic                  lk_taken;

    assign lk_idx = btb.pc[INDEX_BITS-1:0];
    assign lk_tag = btb.pc[WORD-1:INDEX_BITS];
    assign lk_hit = reset_n && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
`ifdef BTB_COUNTER_EN
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];
`else
    assign lk_taken = lk_hit;
`endif

    assign btb.no_btb        = !lk_hit;
    assign btb.predict_taken = lk_taken;
    assign btb.predicted_pc  = lk_taken ? target_q[lk_idx] : btb.pc + PC_STEP;

    // Update-side probe, evaluated against contents before this edge's write.
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_hit;

    assign up_idx = upd.pc[INDEX_BITS-1:0];
    assign up_tag = upd.pc[WORD-1:INDEX_BITS];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic             we;
        logic             v_q;
        logic [TAG_W-1:0] t_q;
        logic [WORD-1:0]  tg_q;

        assign we = upd.vld && (up_idx == INDEX_BITS'(i));

`ifdef BTB_COUNTER_EN
        logic [1:0] c_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q  <= 1'b0;
                t_q  <= '0;
                tg_q <= '0;
                c_q  <= 2'b01;
            end else if (we) begin
                if (up_hit) begin
                    tg_q <= upd.target;
                    c_q  <= ctr_step(c_q, upd.taken);
                end else begin
                    v_q  <= 1'b1;
                    t_q  <= up_tag;
                    tg_q <= upd.target;
                    c_q  <= upd.taken ? 2'b10 : 2'b01;
                end
            end
        end

        assign ctr_q[i] = c_q;
`else
        // Without counters a not-taken resolution evicts; it never allocates.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q  <= 1'b0;
                t_q  <= '0;
                tg_q <= '0;
            end else if (we) begin
                if (upd.taken) begin
                    v_q  <= 1'b1;
                    t_q  <= up_tag;
                    tg_q <= upd.target;
                end else if (up_hit) begin
                    v_q  <= 1'b0;
                end
            end
        end
`endif

        assign valid_q[i]  = v_q;
        assign tag_q[i]    = t_q;
        assign target_q[i] = tg_q;
    end

    logic [15:0] hit_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hit_cnt_q <= '0;
        else if (upd.vld && up_hit)
            hit_cnt_q <= hit_cnt_q + 16'd1;
    end

    assign btb.hit_count = hit_cnt_q;
endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor; covers both BTB_COUNTER_EN builds.
module tb_btb_predictor;
    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;
    logic [15:0] exp_hits;

    btb_predictor_if #(.WORD(16)) bif ();

    btb_predictor #(.WORD(16), .INDEX_BITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btb     (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_update(input logic [15:0] upc, input logic [15:0] tgt, input logic tk);
        @(posedge clk); #1;
        bif.update_pc     = upc;
        bif.update_target = tgt;
        bif.update_taken  = tk;
        bif.update_valid  = 1'b1;
        @(posedge clk); #1;
        bif.update_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bif.pc = 16'h0010;
        #1;
        tests_run++;
        if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL reset_no_btb got %b want 1", bif.no_btb); end
        tests_run++;
        if (bif.predict_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_taken got %b want 0", bif.predict_taken); end
        tests_run++;
        if (bif.predicted_pc !== 16'h0011) begin tests_failed++; $display("FAIL reset_ppc got %h want 0011", bif.predicted_pc); end
        tests_run++;
        if (bif.hit_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_hits got %h want 0000", bif.hit_count); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_hits = 16'h0000;
    endtask

    task automatic test_alloc_hit();
        do_update(16'h0010, 16'h0040, 1'b1);
        bif.pc = 16'h0010;
        #1;
        tests_run++;
        if (bif.no_btb !== 1'b0) begin tests_failed++; $display("FAIL alloc_no_btb got %b want 0", bif.no_btb); end
        tests_run++;
        if (bif.predict_taken !== 1'b1) begin tests_failed++; $display("FAIL alloc_taken got %b want 1", bif.predict_taken); end
        tests_run++;
        if (bif.predicted_pc !== 16'h0040) begin tests_failed++; $display("FAIL alloc_ppc got %h want 0040", bif.predicted_pc); end
        tests_run++;
        if (bif.hit_count !== exp_hits) begin tests_failed++; $display("FAIL alloc_hits got %h want %h", bif.hit_count, exp_hits); end
    endtask

    task automatic test_counter();
        bif.pc = 16'h0010;
`ifdef BTB_COUNTER_EN
        // ctr 10 -> 01 -> 00
        do_update(16'h0010, 16'h0040, 1'b0);
        do_update(16'h0010, 16'h0040, 1'b0);
        exp_hits = exp_hits + 16'd2;
        tests_run++;
        if (bif.predict_taken !== 1'b0) begin tests_failed++; $display("FAIL ctr00_taken got %b want 0", bif.predict_taken); end
        tests_run++;
        if (bif.predicted_pc !== 16'h0011) begin tests_failed++; $display("FAIL ctr00_ppc got %h want 0011", bif.predicted_pc); end
        tests_run++;
        if (bif.no_btb !== 1'b0) begin tests_failed++; $display("FAIL ctr00_no_btb got %b want 0", bif.no_btb); end
        // 00 -> 01 still not taken
        do_update(16'h0010, 16'h0040, 1'b1);
        tests_run++;
        if (bif.predict_taken !== 1'b0) begin tests_failed++; $display("FAIL ctr01_taken got %b want 0", bif.predict_taken); end
        do_update(16'h0010, 16'h0040, 1'b1);
        do_update(16'h0010, 16'h0040, 1'b1);
        exp_hits = exp_hits + 16'd3;
        tests_run++;
        if (bif.predicted_pc !== 16'h0040) begin tests_failed++; $display("FAIL ctr11_ppc got %h want 0040", bif.predicted_pc); end
        // Saturated at 11: one more taken then one not-taken leaves 10 (taken)
        do_update(16'h0010, 16'h0040, 1'b1);
        do_update(16'h0010, 16'h0040, 1'b0);
        exp_hits = exp_hits + 16'd2;
        tests_run++;
        if (bif.predict_taken !== 1'b1) begin tests_failed++; $display("FAIL ctr_sat_taken got %b want 1", bif.predict_taken); end
        tests_run++;
        if (bif.hit_count !== exp_hits) begin tests_failed++; $display("FAIL ctr_hits got %h want %h", bif.hit_count, exp_hits); end
`else
        do_update(16'h0010, 16'h0040, 1'b0);
        exp_hits = exp_hits + 16'd1;
        tests_run++;
        if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL evict_no_btb got %b want 1", bif.no_btb); end
        tests_run++;
        if (bif.predicted_pc !== 16'h0011) begin tests_failed++; $display("FAIL evict_ppc got %h want 0011", bif.predicted_pc); end
        // Not-taken on a miss must not allocate
        do_update(16'h0010, 16'h0050, 1'b0);
        tests_run++;
        if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL nt_miss_no_btb got %b want 1", bif.no_btb); end
        tests_run++;
        if (bif.hit_count !== exp_hits) begin tests_failed++; $display("FAIL nt_hits got %h want %h", bif.hit_count, exp_hits); end
        do_update(16'h0010, 16'h0040, 1'b1);
        tests_run++;
        if (bif.predicted_pc !== 16'h0040) begin tests_failed++; $display("FAIL realloc_ppc got %h want 0040", bif.predicted_pc); end
`endif
    endtask

    task automatic test_alias();
        do_update(16'h0110, 16'h0200, 1'b1);
        bif.pc = 16'h0010;
        #1;
        tests_run++;
        if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL alias_old_no_btb got %b want 1", bif.no_btb); end
        bif.pc = 16'h0110;
        #1;
        tests_run++;
        if (bif.predicted_pc !== 16'h0200) begin tests_failed++; $display("FAIL alias_new_ppc got %h want 0200", bif.predicted_pc); end
        tests_run++;
        if (bif.hit_count !== exp_hits) begin tests_failed++; $display("FAIL alias_hits got %h want %h", bif.hit_count, exp_hits); end
    endtask

    task automatic test_same_cycle();
        @(posedge clk); #1;
        bif.pc            = 16'h0020;
        bif.update_pc     = 16'h0020;
        bif.update_target = 16'h0080;
        bif.update_taken  = 1'b1;
        bif.update_valid  = 1'b1;
        #1;
        tests_run++;
        if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL same_pre_no_btb got %b want 1", bif.no_btb); end
        @(posedge clk); #1;
        bif.update_valid = 1'b0;
        tests_run++;
        if (bif.no_btb !== 1'b0) begin tests_failed++; $display("FAIL same_post_no_btb got %b want 0", bif.no_btb); end
        tests_run++;
        if (bif.predicted_pc !== 16'h0080) begin tests_failed++; $display("FAIL same_post_ppc got %h want 0080", bif.predicted_pc); end
        tests_run++;
        if (bif.hit_count !== exp_hits) begin tests_failed++; $display("FAIL same_hits got %h want %h", bif.hit_count, exp_hits); end
    endtask

    task automatic test_wrap_reset();
        logic [15:0] probe [4];
        probe[0] = 16'h0110; probe[1] = 16'h0020; probe[2] = 16'h0030; probe[3] = 16'h0010;
        bif.pc = 16'hFFFF;
        #1;
        tests_run++;
        if (bif.predicted_pc !== 16'h0000) begin tests_failed++; $display("FAIL wrap_ppc got %h want 0000", bif.predicted_pc); end
        tests_run++;
        if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL wrap_no_btb got %b want 1", bif.no_btb); end
        // Hit on 0x0110 in flight when reset lands mid-cycle
        @(posedge clk); #1;
        bif.pc            = 16'h0110;
        bif.update_pc     = 16'h0110;
        bif.update_target = 16'h0300;
        bif.update_taken  = 1'b1;
        bif.update_valid  = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL inrst_no_btb got %b want 1", bif.no_btb); end
        tests_run++;
        if (bif.predicted_pc !== 16'h0111) begin tests_failed++; $display("FAIL inrst_ppc got %h want 0111", bif.predicted_pc); end
        tests_run++;
        if (bif.predict_taken !== 1'b0) begin tests_failed++; $display("FAIL inrst_taken got %b want 0", bif.predict_taken); end
        @(posedge clk); #1;
        bif.update_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bif.pc = probe[i];
            #1;
            tests_run++;
            if (bif.no_btb !== 1'b1) begin tests_failed++; $display("FAIL postrst_no_btb pc=%h got %b want 1", probe[i], bif.no_btb); end
        end
        tests_run++;
        if (bif.hit_count !== 16'h0000) begin tests_failed++; $display("FAIL postrst_hits got %h want 0000", bif.hit_count); end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        exp_hits          = 16'h0000;
        bif.pc            = 16'h0000;
        bif.update_valid  = 1'b0;
        bif.update_pc     = 16'h0000;
        bif.update_target = 16'h0000;
        bif.update_taken  = 1'b0;
        test_reset();
        test_alloc_hit();
        test_counter();
        test_alias();
        test_same_cycle();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
